// File: rtl/sha1_block_iter.sv
// Iterative SHA-1 compression of one 512-bit block, ROUNDS_PER_CLK rounds per clock.
// Optional SHA1_CHAIN_EN adds a `first` input for internal multi-block chaining.
module sha1_block_iter #(
    parameter int ROUNDS_PER_CLK = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [159:0] context_in,
    input  logic [511:0] block,
`ifdef SHA1_CHAIN_EN
    input  logic         first,
`endif
    output logic         ready,
    output logic         done,
    output logic [159:0] context_out
);

    localparam int         R      = ROUNDS_PER_CLK;
    localparam logic [6:0] R_STEP = 7'(R);

    generate
        if (R < 1 || R > 80 || (80 % R) != 0) begin : g_bad_rounds
            $error("sha1_block_iter: ROUNDS_PER_CLK must divide 80");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

    state_t       state_reg, state_next;
    logic [6:0]   cnt_reg, cnt_next;
    logic [31:0]  w_reg [16];
    logic [31:0]  w_next [16];
    logic [31:0]  a_reg, b_reg, c_reg, d_reg, e_reg;
    logic [31:0]  a_next, b_next, c_next, d_next, e_next;
    logic [159:0] h_reg, h_next;
    logic [159:0] ctx_reg, ctx_next;
    logic         done_reg, done_next;

    logic [31:0]  blk_word [16];
    logic [31:0]  ext [R + 16];
    logic [31:0]  rnd_a, rnd_b, rnd_c, rnd_d, rnd_e;
    logic [159:0] work;
    logic [159:0] fin_sum;
    logic [159:0] init_ctx;
    logic         load;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    assign work = {a_reg, b_reg, c_reg, d_reg, e_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk
            assign blk_word[gi] = block[511 - 32*gi -: 32];
        end
        for (gi = 0; gi < 5; gi++) begin : g_fin
            assign fin_sum[159 - 32*gi -: 32] = h_reg[159 - 32*gi -: 32] + work[159 - 32*gi -: 32];
        end
    endgenerate

    // The FIN cycle also accepts a new block so back-to-back blocks lose no clock.
    assign ready = (state_reg == ST_IDLE) || (state_reg == ST_FIN);
    assign load  = start && ready;

`ifdef SHA1_CHAIN_EN
    // Chaining from the result being written this very edge when accepted in FIN.
    assign init_ctx = first ? context_in : ((state_reg == ST_FIN) ? fin_sum : ctx_reg);
`else
    assign init_ctx = context_in;
`endif

    // ext[j] is W[cnt+j]; the first 16 come from the window, the rest are expanded here.
    always_comb begin : round_logic
        logic [31:0] f, k, temp;
        logic [6:0]  t;
        f    = '0;
        k    = '0;
        temp = '0;
        t    = '0;
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_reg[i];
        end
        for (int i = 16; i < R + 16; i++) begin
            ext[i] = rotl(ext[i-3] ^ ext[i-8] ^ ext[i-14] ^ ext[i-16], 1);
        end
        rnd_a = a_reg;
        rnd_b = b_reg;
        rnd_c = c_reg;
        rnd_d = d_reg;
        rnd_e = e_reg;
        for (int j = 0; j < R; j++) begin
            t = cnt_reg + 7'(j);
            if (t < 7'd20) begin
                f = (rnd_b & rnd_c) | (~rnd_b & rnd_d);
                k = 32'h5A827999;
            end else if (t < 7'd40) begin
                f = rnd_b ^ rnd_c ^ rnd_d;
                k = 32'h6ED9EBA1;
            end else if (t < 7'd60) begin
                f = (rnd_b & rnd_c) | (rnd_b & rnd_d) | (rnd_c & rnd_d);
                k = 32'h8F1BBCDC;
            end else begin
                f = rnd_b ^ rnd_c ^ rnd_d;
                k = 32'hCA62C1D6;
            end
            temp  = rotl(rnd_a, 5) + f + rnd_e + k + ext[j];
            rnd_e = rnd_d;
            rnd_d = rnd_c;
            rnd_c = rotl(rnd_b, 30);
            rnd_b = rnd_a;
            rnd_a = temp;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        w_next     = w_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        d_next     = d_reg;
        e_next     = e_reg;
        h_next     = h_reg;
        ctx_next   = ctx_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: ;
            ST_RUN: begin
                a_next = rnd_a;
                b_next = rnd_b;
                c_next = rnd_c;
                d_next = rnd_d;
                e_next = rnd_e;
                for (int i = 0; i < 16; i++) begin
                    w_next[i] = ext[i + R];
                end
                cnt_next = cnt_reg + R_STEP;
                if (cnt_reg + R_STEP == 7'd80) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                ctx_next   = fin_sum;
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (load) begin
            w_next = blk_word;
            {a_next, b_next, c_next, d_next, e_next} = init_ctx;
            h_next     = init_ctx;
            cnt_next   = '0;
            state_next = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            for (int i = 0; i < 16; i++) begin
                w_reg[i] <= '0;
            end
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            d_reg    <= '0;
            e_reg    <= '0;
            h_reg    <= '0;
            ctx_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            w_reg     <= w_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            c_reg     <= c_next;
            d_reg     <= d_next;
            e_reg     <= e_next;
            h_reg     <= h_next;
            ctx_reg   <= ctx_next;
            done_reg  <= done_next;
        end
    end

    assign done        = done_reg;
    assign context_out = ctx_reg;

endmodule

// File: tb/tb_sha1_block_iter.sv
// Bench for sha1_block_iter: two instances (1 and 4 rounds/clock) checked every cycle
// against a plain SHA-1 model; known digests pin the model itself.
module tb_sha1_block_iter;

    localparam logic [159:0] IV       = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [159:0] DG_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;
    localparam logic [159:0] DG_ABC   = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] DG_TWO   = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;
    localparam logic [447:0] MSG2     = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    localparam logic [511:0] BLK_EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] BLK_ABC   = {24'h616263, 8'h80, 416'd0, 64'd24};
    localparam logic [511:0] BLK_TWO_A = {MSG2, 8'h80, 56'd0};
    localparam logic [511:0] BLK_TWO_B = {448'd0, 64'd448};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   start_s = '0;
    logic [159:0] context_in = '0;
    logic [511:0] block = '0;
`ifdef SHA1_CHAIN_EN
    logic         first = 1'b1;
`endif
    logic [1:0]   ready_s, done_s;
    logic [159:0] ctx_s [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha1_block_iter #(.ROUNDS_PER_CLK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .context_in(context_in), .block(block),
`ifdef SHA1_CHAIN_EN
        .first(first),
`endif
        .ready(ready_s[0]), .done(done_s[0]), .context_out(ctx_s[0]));

    sha1_block_iter #(.ROUNDS_PER_CLK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .context_in(context_in), .block(block),
`ifdef SHA1_CHAIN_EN
        .first(first),
`endif
        .ready(ready_s[1]), .done(done_s[1]), .context_out(ctx_s[1]));

    function automatic int lat(input int d);
        return (d == 0) ? 81 : 21;
    endfunction

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Straight textbook SHA-1 compression with a full 80-word schedule.
    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] m);
        logic [31:0] w [80];
        logic [31:0] va, vb, vc, vd, ve, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 80; t++) w[t] = rol(w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16], 1);
        {va, vb, vc, vd, ve} = h;
        for (int t = 0; t < 80; t++) begin
            case (t / 20)
                0:       begin f = (vb & vc) | (~vb & vd);            k = 32'h5A827999; end
                1:       begin f = vb ^ vc ^ vd;                      k = 32'h6ED9EBA1; end
                2:       begin f = (vb & vc) | (vb & vd) | (vc & vd); k = 32'h8F1BBCDC; end
                default: begin f = vb ^ vc ^ vd;                      k = 32'hCA62C1D6; end
            endcase
            tmp = rol(va, 5) + f + ve + k + w[t];
            ve = vd; vd = vc; vc = rol(vb, 30); vb = va; va = tmp;
        end
        return {h[159:128] + va, h[127:96] + vb, h[95:64] + vc, h[63:32] + vd, h[31:0] + ve};
    endfunction

    function automatic logic [159:0] rand160();
        logic [159:0] v;
        for (int i = 0; i < 5; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: a block accepted at edge k completes at edge k+lat.
    logic         m_busy [2];
    logic         m_done [2];
    int           m_rem  [2];
    logic [159:0] m_ctx  [2];
    logic [159:0] m_pend [2];

    function automatic logic [159:0] model_init(input int d);
`ifdef SHA1_CHAIN_EN
        if (!first) return (m_busy[d] && m_rem[d] == 1) ? m_pend[d] : m_ctx[d];
`endif
        return context_in;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] <= 1'b0;
                m_done[d] <= 1'b0;
                m_rem[d]  <= 0;
                m_ctx[d]  <= '0;
                m_pend[d] <= '0;
            end else begin
                m_done[d] <= m_busy[d] && m_rem[d] == 1;
                if (m_busy[d] && m_rem[d] == 1) m_ctx[d] <= m_pend[d];
                if ((!m_busy[d] || m_rem[d] == 1) && start_s[d]) begin
                    m_busy[d] <= 1'b1;
                    m_rem[d]  <= lat(d);
                    m_pend[d] <= sha1_compress(model_init(d), block);
                end else if (m_busy[d]) begin
                    m_busy[d] <= (m_rem[d] != 1);
                    m_rem[d]  <= m_rem[d] - 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cyc%0d dut%0d ready", cyc, d), {159'd0, ready_s[d]},
                      {159'd0, (!m_busy[d] || m_rem[d] == 1)});
                check($sformatf("cyc%0d dut%0d done", cyc, d), {159'd0, done_s[d]}, {159'd0, m_done[d]});
                check($sformatf("cyc%0d dut%0d context_out", cyc, d), ctx_s[d], m_ctx[d]);
            end
        end
    end

    task automatic wait_ready(input int d);
        int n = 0;
        while (ready_s[d] !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check($sformatf("dut%0d ready_seen", d), {159'd0, ready_s[d]}, 160'd1);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (done_s[d] !== 1'b1 && n < 300);
        check($sformatf("dut%0d done_seen", d), {159'd0, done_s[d]}, 160'd1);
    endtask

    task automatic issue(input int d, input logic [159:0] ctx, input logic [511:0] blk, output int acc);
        wait_ready(d);
        context_in = ctx;
        block      = blk;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        acc        = cyc;
        start_s[d] = 1'b0;
    endtask

    task automatic count_no_done(input int d, input int cycles, input string name);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done_s[d] === 1'b1) seen++;
        end
        check(name, 160'(seen), 160'd0);
    endtask

    task automatic run_one(input int d, input logic [159:0] ctx, input logic [511:0] blk,
                           input logic [159:0] exp, input string name);
        int acc;
        issue(d, ctx, blk, acc);
        wait_done(d);
        check($sformatf("dut%0d %s latency", d, name), 160'(cyc - acc), 160'(lat(d)));
        check($sformatf("dut%0d %s digest", d, name), ctx_s[d], exp);
        $display("[TB] dut%0d %s: latency %0d digest %h", d, name, cyc - acc, ctx_s[d]);
    endtask

    initial begin
        int acc, t1, t2;
        logic [159:0] mid;
        mid = sha1_compress(IV, BLK_TWO_A);

        // Pin the reference model to published digests.
        check("model empty", sha1_compress(IV, BLK_EMPTY), DG_EMPTY);
        check("model abc", sha1_compress(IV, BLK_ABC), DG_ABC);
        check("model two-block", sha1_compress(mid, BLK_TWO_B), DG_TWO);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d reset ready", d), {159'd0, ready_s[d]}, 160'd1);
            check($sformatf("dut%0d reset done", d), {159'd0, done_s[d]}, 160'd0);
            check($sformatf("dut%0d reset context", d), ctx_s[d], 160'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d idle ready", d), {159'd0, ready_s[d]}, 160'd1);
            check($sformatf("dut%0d idle context", d), ctx_s[d], 160'd0);
        end

        for (int d = 0; d < 2; d++) begin
            run_one(d, IV, BLK_EMPTY, DG_EMPTY, "empty");
            run_one(d, IV, BLK_ABC, DG_ABC, "abc");

            // Two-block message with start held high across the first completion.
            wait_ready(d);
            context_in = IV;
            block      = BLK_TWO_A;
            start_s[d] = 1'b1;
            @(posedge clk); #1;
            acc   = cyc;
            block = BLK_TWO_B;
`ifdef SHA1_CHAIN_EN
            first      = 1'b0;
            context_in = rand160();
`else
            context_in = mid;
`endif
            wait_done(d);
            t1 = cyc;
            start_s[d] = 1'b0;
            check($sformatf("dut%0d two-block first latency", d), 160'(t1 - acc), 160'(lat(d)));
            check($sformatf("dut%0d two-block first digest", d), ctx_s[d], mid);
            wait_done(d);
            t2 = cyc;
`ifdef SHA1_CHAIN_EN
            first = 1'b1;
`endif
            check($sformatf("dut%0d two-block spacing", d), 160'(t2 - t1), 160'(lat(d)));
            check($sformatf("dut%0d two-block digest", d), ctx_s[d], DG_TWO);
            $display("[TB] dut%0d two-block: spacing %0d digest %h", d, t2 - t1, ctx_s[d]);

            // Start pulsed mid-run with garbage is ignored.
            issue(d, IV, BLK_ABC, acc);
            repeat (2) begin @(posedge clk); #1; end
            block      = rand512();
            context_in = rand160();
            start_s[d] = 1'b1;
            @(posedge clk); #1;
            start_s[d] = 1'b0;
            wait_done(d);
            check($sformatf("dut%0d ignore-start digest", d), ctx_s[d], DG_ABC);
            count_no_done(d, lat(d) + 3, $sformatf("dut%0d ignore-start extra done", d));
            $display("[TB] dut%0d ignore-start: digest %h", d, ctx_s[d]);

            // Reset in the middle of a run.
            issue(d, IV, BLK_EMPTY, acc);
            repeat ((d == 0) ? 39 : 9) begin @(posedge clk); #1; end
            @(negedge clk) rst_n = 1'b0;
            #1;
            check($sformatf("dut%0d midrun-reset ready", d), {159'd0, ready_s[d]}, 160'd1);
            check($sformatf("dut%0d midrun-reset done", d), {159'd0, done_s[d]}, 160'd0);
            check($sformatf("dut%0d midrun-reset context", d), ctx_s[d], 160'd0);
            repeat (2) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            count_no_done(d, lat(d) + 3, $sformatf("dut%0d midrun-reset no done", d));
            $display("[TB] dut%0d midrun-reset: context %h", d, ctx_s[d]);
            run_one(d, IV, BLK_EMPTY, DG_EMPTY, "empty-after-reset");

            // Random blocks and contexts, some with stray mid-run start pulses.
            for (int i = 0; i < 6; i++) begin
`ifdef SHA1_CHAIN_EN
                first = ($urandom_range(0, 3) != 0);
`endif
                issue(d, rand160(), rand512(), acc);
                block = rand512();
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(0, lat(d) - 3)) begin @(posedge clk); #1; end
                    block      = rand512();
                    start_s[d] = 1'b1;
                    @(posedge clk); #1;
                    start_s[d] = 1'b0;
                end
                wait_done(d);
                check($sformatf("dut%0d random%0d latency", d, i), 160'(cyc - acc), 160'(lat(d)));
                $display("[TB] dut%0d random%0d: digest %h", d, i, ctx_s[d]);
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
`ifdef SHA1_CHAIN_EN
            first = 1'b1;
`endif
        end

        repeat (2) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
